// File: rtl/bit_serial_subtractor_if.sv
// bit_serial_subtractor_if: start/operand request and result/flag bundle
interface bit_serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;
  modport master (output start, a, b, input busy, done, diff, borrow, overflow, zero);
  modport slave  (input start, a, b, output busy, done, diff, borrow, overflow, zero);
endinterface

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: LSB-first A-B using one full adder on ~B with carry seeded to 1
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  bit_serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, diff_q, diff_nx;
  logic [CW-1:0] cnt;
  logic carry, s, carry_nx, sign_a, sign_b, borrow_q, overflow_q, zero_q, last;
  assign s        = a_sh[0] ^ ~b_sh[0] ^ carry;
  assign carry_nx = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & carry) | (~b_sh[0] & carry);
  assign diff_nx  = {s, diff_q[WIDTH-1:1]};
  assign last     = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? SHIFT : IDLE;
      SHIFT:   state_nx = last ? DONE : SHIFT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      diff_q     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      diff_q <= '0;
      cnt    <= '0;
      carry  <= 1'b1;
      sign_a <= bus.a[WIDTH-1];
      sign_b <= bus.b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      diff_q <= diff_nx;
      carry  <= carry_nx;
      cnt    <= cnt + 1'b1;
      // flags come from the final bit's combinational values so they land with done
      if (last) begin
        borrow_q   <= ~carry_nx;
        overflow_q <= (sign_a != sign_b) && (s != sign_a);
        zero_q     <= diff_nx == '0;
      end
    end
  assign bus.busy     = state == SHIFT;
  assign bus.done     = state == DONE;
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb_bit_serial_subtractor: directed vector table plus handshake, reset and back-to-back sequences
module tb_bit_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  bit_serial_subtractor_if #(.WIDTH(8)) bus ();
  bit_serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    logic       zero;
  } vec_t;
  vec_t vecs[9];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_op(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    bus.a = v.a;
    bus.b = v.b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({nm, " busy"}, 32'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, " latency"}, n, 8);
    check({nm, " diff"}, 32'(bus.diff), 32'(v.diff));
    check({nm, " borrow"}, 32'(bus.borrow), 32'(v.borrow));
    check({nm, " overflow"}, 32'(bus.overflow), 32'(v.ovf));
    check({nm, " zero"}, 32'(bus.zero), 32'(v.zero));
    check({nm, " busy at done"}, 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    check({nm, " done pulse"}, 32'(bus.done), 0);
    check({nm, " diff hold"}, 32'(bus.diff), 32'(v.diff));
  endtask
  initial begin
    int dones, last_t, t;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 1'b0};
    #22;
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset diff", 32'(bus.diff), 0);
    check("reset flags", {bus.borrow, bus.overflow, bus.zero}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));
    // start pulsed mid-operation must be ignored
    @(negedge clk);
    bus.a = 8'h44;
    bus.b = 8'h22;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.a = 8'h33;
    bus.b = 8'h11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        check("ignore diff", 32'(bus.diff), 32'h22);
      end
    end
    check("ignore done count", dones, 1);
    // async reset mid-SHIFT; previous flags (borrow/overflow from 7F-80) are still held
    run_op(vecs[8], "pre-reset");
    @(negedge clk);
    bus.a = 8'h44;
    bus.b = 8'h22;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(bus.busy), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst diff", 32'(bus.diff), 0);
    check("rst flags", {bus.borrow, bus.overflow, bus.zero}, 0);
    #10;
    rst_n = 1'b1;
    run_op('{8'h09, 8'h03, 8'h06, 1'b0, 1'b0, 1'b0}, "post-reset");
    // start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    bus.a = 8'h7F;
    bus.b = 8'h80;
    bus.start = 1'b1;
    dones = 0;
    last_t = -1;
    t = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      t = i;
      if (bus.done) begin
        dones++;
        if (last_t >= 0) check("b2b period", t - last_t, 10);
        else check("b2b first", t, 9);
        last_t = t;
        check("b2b diff", 32'(bus.diff), 32'hFF);
        check("b2b flags", {bus.borrow, bus.overflow, bus.zero}, 3'b110);
      end
    end
    check("b2b count", dones, 4);
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while ((bus.busy || bus.done) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drain", t < 20, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
